crossbar_control_scheduler: RTL and testbench
=============================================

# crossbar_control_scheduler

Control-side initiator for the blocking crossbar. Accepts per-input route requests (destination output plus packet length), picks one requester by round-robin, issues the matching control word over the crossbar's control val/rdy interface, then holds off further control words until the granted packet's last beat has crossed the crossbar's input handshake. It sits beside the crossbar and drives its `control`/`control_val`/`control_rdy` port, tapping the crossbar's per-input `recv_val`/`recv_rdy` to count beats.

## Interface
- `N_INPUTS`, 2: crossbar inputs; must be ≥ 2.
- `N_OUTPUTS`, 2: crossbar outputs; must be ≥ 2.
- `CONTROL_BIT_WIDTH`, 42: control word width; must be ≥ IW+OW.
- `LEN_W`, 8: packet length field width.
- Derived: IW = $clog2(N_INPUTS), OW = $clog2(N_OUTPUTS).

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_val[0:N_INPUTS-1]` in 1 each: input i requests a route.
- `req_dest[0:N_INPUTS-1]` in OW each: requested output index.
- `req_len[0:N_INPUTS-1]` in LEN_W each: packet beats minus one (0 = 1 beat).
- `req_rdy[0:N_INPUTS-1]` out 1 each: request accepted this cycle.
- `control` out CONTROL_BIT_WIDTH: word to crossbar.
- `control_val` out 1.
- `control_rdy` in 1.
- `mon_val[0:N_INPUTS-1]` in 1 each: tap of crossbar `recv_val`.
- `mon_rdy[0:N_INPUTS-1]` in 1 each: tap of crossbar `recv_rdy`.
- `busy` out 1: a grant is outstanding (SEND or XFER).
- `grant_id` out IW: currently or last granted input.

## Operation
- Control word format: bits [CBW-1 : CBW-IW] = input index; bits [CBW-IW-1 : CBW-IW-OW] = output index; all lower bits 0.
- Registers: state, rr_ptr (IW), sel_in (IW), sel_out (OW), len (LEN_W), beat_cnt (LEN_W).
- IDLE: `control_val`=0, `busy`=0. If any `req_val`, the winner is the first i with `req_val[i]`=1, scanning rr_ptr, rr_ptr+1, … modulo N_INPUTS. In the same cycle, assert `req_rdy[winner]`=1 (combinational, one-hot, only in IDLE). Latch sel_in=winner, sel_out=`req_dest[winner]`, len=`req_len[winner]`, and set `grant_id`=winner. Next state is SEND.
- SEND: `control_val`=1 and `control` = formatted {sel_in, sel_out}, held stable until `control_rdy`=1. On fire, clear beat_cnt and go to XFER.
- XFER: a beat is `mon_val[sel_in] & mon_rdy[sel_in]`. On each beat, beat_cnt++. A beat with beat_cnt==len is the last beat: go to IDLE and set rr_ptr = sel_in+1 (wraps from N_INPUTS-1 to 0).
- Beats on non-selected inputs, and any beats in IDLE/SEND, are ignored.
- `req_dest` ≥ N_OUTPUTS: passed through unchecked; the word carries the low OW bits.
- `req_rdy` is all-zero in SEND and XFER; requests stay pending.

## Timing
- Reset values: state=IDLE, `control`=0, `control_val`=0, `req_rdy` all 0, `busy`=0, `grant_id`=0, rr_ptr=0, beat_cnt=0.
- Reset mid-SEND or mid-XFER: next cycle is IDLE with the reset values; the grant is abandoned and no word is issued.
- Request accept to `control_val`: 1 cycle (accept in cycle T, `control_val` high from T+1).
- Control fire in cycle C: the crossbar routes from C+1; the first beat is counted at the earliest in C+1.
- Last beat in cycle L: IDLE in L+1, and a new `req_rdy` is possible in L+1.
- Minimum per-packet overhead: 2 cycles (accept + SEND) before the first routed beat.
- `control`/`control_val` are registered outputs; `req_rdy` is combinational from state, `req_val`, and rr_ptr.
- beat_cnt never wraps, because exit occurs at beat_cnt==len; len = 2^LEN_W−1 gives 2^LEN_W beats.

## Test plan
- Single request: reset; `req_val[1]`=1, dest=0, len=2 → `req_rdy[1]` for one cycle. `control_val` on the next cycle with `control`[41]=1, [40]=0, rest 0. With `control_rdy`=1, exactly 3 beats on input 1 return to IDLE; `busy` falls one cycle after the 3rd beat.
- Round-robin fairness: both `req_val` held high, each len=0, one beat each → grants alternate 0,1,0,1; `grant_id` toggles each packet.
- Backpressure: `control_rdy`=0 for 5 cycles in SEND → `control_val` stays 1 and `control` stays stable; the transition to XFER happens only in the cycle `control_rdy`=1.
- Beat stalls: in XFER with len=1, `mon_val`=1, `mon_rdy` toggling 0,1,0,0,1 → exit after the second fire. Beats on the unselected input do not advance beat_cnt.
- Reset mid-XFER: grant input 0, len=5, reset after 2 beats → all outputs at reset values next cycle. A subsequent request from input 1 is granted first (rr_ptr=0, only input 1 valid).
- Max length: len=255 → exactly 256 beats counted before IDLE, with no early exit.

Source files
------------

// File: rtl/crossbar_control_scheduler.sv
// crossbar_control_scheduler
//   Control-side initiator for the blocking crossbar. Picks one pending route
//   request by round-robin and issues the matching control word on the
//   crossbar's control val/rdy port. It then waits until the granted packet's
//   last beat has crossed that input's recv handshake before it accepts the
//   next request.
//
// Ports
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   req_val[i]    : input i requests a route
//   req_dest[i]   : requested output index (low OW bits are used)
//   req_len[i]    : packet beats minus one
//   req_rdy[i]    : request accepted this cycle (combinational, one-hot, IDLE only)
//   control       : control word {input, output, zeros}
//   control_val   : control word valid
//   control_rdy   : crossbar accepts control word
//   mon_val[i]    : tap of crossbar recv_val
//   mon_rdy[i]    : tap of crossbar recv_rdy
//   busy          : a grant is outstanding
//   grant_id      : currently or last granted input
module crossbar_control_scheduler #(
  parameter  int N_INPUTS          = 2,
  parameter  int N_OUTPUTS         = 2,
  parameter  int CONTROL_BIT_WIDTH = 42,
  parameter  int LEN_W             = 8,
  localparam int IW                = $clog2(N_INPUTS),
  localparam int OW                = $clog2(N_OUTPUTS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_val  [0:N_INPUTS-1],
  input  logic [OW-1:0]                req_dest [0:N_INPUTS-1],
  input  logic [LEN_W-1:0]             req_len  [0:N_INPUTS-1],
  output logic                         req_rdy  [0:N_INPUTS-1],
  output logic [CONTROL_BIT_WIDTH-1:0] control,
  output logic                         control_val,
  input  logic                         control_rdy,
  input  logic                         mon_val  [0:N_INPUTS-1],
  input  logic                         mon_rdy  [0:N_INPUTS-1],
  output logic                         busy,
  output logic [IW-1:0]                grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    sel_in;
  logic [OW-1:0]    sel_out;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] beat_cnt;

  logic             found;
  logic [IW-1:0]    winner;
  int unsigned      idx;
  logic             beat;
  logic             last_beat;
  logic [IW-1:0]    next_ptr;

  // Round-robin scan starting at rr_ptr; the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < N_INPUTS; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_INPUTS) idx = idx - N_INPUTS;
      if (!found && req_val[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      req_rdy[i] = (state == IDLE) && found && (winner == IW'(i));
    end
  end

  // The word is pure wiring of the sel_in/sel_out registers, so it is
  // stable for the whole SEND phase and zero after reset.
  always_comb begin
    control = '0;
    control[CONTROL_BIT_WIDTH-1 -: IW]    = sel_in;
    control[CONTROL_BIT_WIDTH-IW-1 -: OW] = sel_out;
  end

  assign beat      = mon_val[sel_in] & mon_rdy[sel_in];
  assign last_beat = beat && (beat_cnt == len);
  assign next_ptr  = (sel_in == IW'(N_INPUTS - 1)) ? '0 : sel_in + IW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      sel_in      <= '0;
      sel_out     <= '0;
      len         <= '0;
      beat_cnt    <= '0;
      control_val <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel_in      <= winner;
            sel_out     <= req_dest[winner];
            len         <= req_len[winner];
            grant_id    <= winner;
            control_val <= 1'b1;
            busy        <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (control_rdy) begin
            control_val <= 1'b0;
            beat_cnt    <= '0;
            state       <= XFER;
          end
        end
        XFER: begin
          // Exit happens on beat_cnt==len, so the counter never wraps.
          if (last_beat) begin
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end else if (beat) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
          end
        end
        default: begin
          control_val <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crossbar_control_scheduler.sv
// Testbench for crossbar_control_scheduler: directed scenarios followed by
// randomized traffic, all checked every cycle against a transaction-level
// reference model (grant queue position, beats remaining, expected word).
module tb_crossbar_control_scheduler;

  localparam int N_IN  = 2;
  localparam int N_OUT = 2;
  localparam int CBW   = 42;
  localparam int LEN_W = 8;
  localparam int IW    = 1;
  localparam int OW    = 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_val  [0:N_IN-1];
  logic [OW-1:0]    req_dest [0:N_IN-1];
  logic [LEN_W-1:0] req_len  [0:N_IN-1];
  logic             req_rdy  [0:N_IN-1];
  logic [CBW-1:0]   control;
  logic             control_val;
  logic             control_rdy;
  logic             mon_val  [0:N_IN-1];
  logic             mon_rdy  [0:N_IN-1];
  logic             busy;
  logic [IW-1:0]    grant_id;

  always #5 clk = ~clk;

  crossbar_control_scheduler #(
    .N_INPUTS(N_IN),
    .N_OUTPUTS(N_OUT),
    .CONTROL_BIT_WIDTH(CBW),
    .LEN_W(LEN_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_val(req_val),
    .req_dest(req_dest),
    .req_len(req_len),
    .req_rdy(req_rdy),
    .control(control),
    .control_val(control_val),
    .control_rdy(control_rdy),
    .mon_val(mon_val),
    .mon_rdy(mon_rdy),
    .busy(busy),
    .grant_id(grant_id)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = no grant, 1 = word offered, 2 = packet in flight.
  int          m_mode = 0;
  int          m_ptr  = 0;
  int          m_in   = 0;
  int          m_out  = 0;
  int          m_left = 0;
  int          m_gid  = 0;
  logic [63:0] m_word = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N_IN; k++) begin
      int i;
      i = (m_ptr + k) % N_IN;
      if (req_val[i] === 1'b1) return i;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < N_IN; i++) begin
      req_val[i]  = 1'b0;
      req_dest[i] = '0;
      req_len[i]  = '0;
      mon_val[i]  = 1'b0;
      mon_rdy[i]  = 1'b0;
    end
    control_rdy = 1'b0;
  endtask

  // Check outputs for the current inputs, then advance one clock and the model.
  task automatic cycle();
    int w;
    #1;
    w = pick();
    for (int i = 0; i < N_IN; i++)
      chk($sformatf("req_rdy[%0d]", i), 64'(req_rdy[i]),
          64'((m_mode == 0 && w == i) ? 1 : 0));
    chk("control_val", 64'(control_val), 64'((m_mode == 1) ? 1 : 0));
    chk("control", 64'(control), m_word);
    chk("busy", 64'(busy), 64'((m_mode != 0) ? 1 : 0));
    chk("grant_id", 64'(grant_id), 64'(m_gid));
    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_ptr = 0; m_in = 0; m_out = 0;
      m_left = 0; m_gid = 0; m_word = '0;
    end else if (m_mode == 0) begin
      if (w >= 0) begin
        m_in   = w;
        m_out  = int'(req_dest[w]) % N_OUT;
        m_left = int'(req_len[w]) + 1;
        m_gid  = w;
        m_word = (64'(m_in) << (CBW - IW)) | (64'(m_out) << (CBW - IW - OW));
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (control_rdy) m_mode = 2;
    end else begin
      if (mon_val[m_in] && mon_rdy[m_in]) begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 0;
          m_ptr  = (m_in + 1) % N_IN;
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [CBW-1:0] cw;
    int             stall [5];
    stall = '{0, 1, 0, 0, 1};

    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    reset = 1'b0;
    cycle();

    // Single request from input 1, dest 0, three beats.
    req_val[1] = 1'b1; req_dest[1] = 1'b0; req_len[1] = 8'd2;
    cycle();
    req_val[1] = 1'b0;
    cw = control;
    chk("single_ctl_in_bit", 64'(cw[41]), 64'd1);
    chk("single_ctl_out_bit", 64'(cw[40]), 64'd0);
    chk("single_ctl_low", 64'(cw[39:0]), 64'd0);
    control_rdy = 1'b1;
    cycle();
    control_rdy = 1'b0;
    mon_val[1] = 1'b1; mon_rdy[1] = 1'b1;
    repeat (3) cycle();
    mon_val[1] = 1'b0; mon_rdy[1] = 1'b0;
    repeat (2) cycle();

    // Round-robin: both inputs always requesting one-beat packets.
    for (int i = 0; i < N_IN; i++) begin
      req_val[i] = 1'b1; req_dest[i] = OW'(1 - i); req_len[i] = '0;
      mon_val[i] = 1'b1; mon_rdy[i] = 1'b1;
    end
    control_rdy = 1'b1;
    repeat (12) cycle();
    clear_inputs();
    cycle();

    // Control backpressure for five cycles.
    req_val[0] = 1'b1; req_dest[0] = 1'b1; req_len[0] = '0;
    cycle();
    req_val[0] = 1'b0;
    repeat (5) cycle();
    control_rdy = 1'b1;
    cycle();
    control_rdy = 1'b0;
    mon_val[0] = 1'b1; mon_rdy[0] = 1'b1;
    cycle();
    clear_inputs();
    cycle();

    // Beat stalls on the selected input, noise on the other input.
    req_val[1] = 1'b1; req_dest[1] = 1'b1; req_len[1] = 8'd1;
    cycle();
    req_val[1] = 1'b0;
    control_rdy = 1'b1;
    cycle();
    control_rdy = 1'b0;
    mon_val[0] = 1'b1; mon_rdy[0] = 1'b1; mon_val[1] = 1'b1;
    foreach (stall[j]) begin
      mon_rdy[1] = stall[j][0];
      cycle();
    end
    clear_inputs();
    repeat (2) cycle();

    // Reset in the middle of a transfer.
    req_val[0] = 1'b1; req_dest[0] = 1'b0; req_len[0] = 8'd5;
    cycle();
    req_val[0] = 1'b0;
    control_rdy = 1'b1;
    cycle();
    control_rdy = 1'b0;
    mon_val[0] = 1'b1; mon_rdy[0] = 1'b1;
    repeat (2) cycle();
    clear_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    req_val[1] = 1'b1; req_dest[1] = 1'b1; req_len[1] = '0;
    cycle();
    req_val[1] = 1'b0;
    chk("post_reset_grant", 64'(grant_id), 64'd1);
    control_rdy = 1'b1;
    cycle();
    mon_val[1] = 1'b1; mon_rdy[1] = 1'b1;
    cycle();
    clear_inputs();
    cycle();

    // Maximum length: 256 beats.
    req_val[0] = 1'b1; req_dest[0] = 1'b1; req_len[0] = 8'd255;
    cycle();
    req_val[0] = 1'b0;
    control_rdy = 1'b1;
    cycle();
    control_rdy = 1'b0;
    mon_val[0] = 1'b1; mon_rdy[0] = 1'b1;
    repeat (255) cycle();
    chk("maxlen_busy_before_last", 64'(busy), 64'd1);
    repeat (3) cycle();
    clear_inputs();
    cycle();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset = 1'b1;
        for (int i = 0; i < N_IN; i++) req_val[i] = 1'b0;
      end else begin
        reset = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
          req_val[i]  = 1'($urandom_range(0, 1));
          req_dest[i] = OW'($urandom_range(0, 1));
          req_len[i]  = LEN_W'($urandom_range(0, 3));
        end
      end
      for (int i = 0; i < N_IN; i++) begin
        mon_val[i] = 1'($urandom_range(0, 1));
        mon_rdy[i] = 1'($urandom_range(0, 1));
      end
      control_rdy = 1'($urandom_range(0, 1));
      cycle();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
